// File: rtl/stream_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter_pkg
//   Shared types and helpers for the packet-aware round-robin stream arbiter.
//   - arb_state_t : arbitration FSM states (IDLE = free to arbitrate,
//                   LOCK = a packet is in progress and owns the output)
//   - clog2()     : index width derivation for requester ids
// -----------------------------------------------------------------------------
package stream_rr_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_WD = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Minimum width able to hold values 0..value-1; never returns 0 so that a
  // degenerate parameterisation still yields legal vector declarations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned w;
    v = (value > 0) ? value - 1 : 0;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter_if
//   Bundles the upstream (pre) and downstream (post) valid/ready streams of
//   stream_rr_arbiter.
//   Upstream, per requester r:
//     valid_pre_i[r], data_pre_i[r*DATA_WD +: DATA_WD], last_pre_i[r] -> arbiter
//     ready_pre_o[r]                                                  <- arbiter
//   Downstream:
//     valid_post_o, data_post_o, last_post_o, id_post_o <- arbiter
//     ready_post_i                                      -> arbiter
//   Modports:
//     master : environment side (drives upstream beats and downstream ready)
//     slave  : arbiter side
// -----------------------------------------------------------------------------
interface stream_rr_arbiter_if
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_WD = DEF_DATA_WD,
  parameter int unsigned ID_WD   = clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]         valid_pre_i;
  logic [NUM_REQ*DATA_WD-1:0] data_pre_i;
  logic [NUM_REQ-1:0]         last_pre_i;
  logic [NUM_REQ-1:0]         ready_pre_o;

  logic                       valid_post_o;
  logic [DATA_WD-1:0]         data_post_o;
  logic                       last_post_o;
  logic [ID_WD-1:0]           id_post_o;
  logic                       ready_post_i;

  modport master (
    output valid_pre_i,
    output data_pre_i,
    output last_pre_i,
    input  ready_pre_o,
    input  valid_post_o,
    input  data_post_o,
    input  last_post_o,
    input  id_post_o,
    output ready_post_i
  );

  modport slave (
    input  valid_pre_i,
    input  data_pre_i,
    input  last_pre_i,
    output ready_pre_o,
    output valid_post_o,
    output data_post_o,
    output last_post_o,
    output id_post_o,
    input  ready_post_i
  );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter_rr_pick
//   Combinational rotating-priority encoder. Returns the first requester with
//   req set, scanning ptr, ptr+1, ... and wrapping modulo NUM_REQ.
//   Ports:
//     req     in  NUM_REQ  request vector
//     ptr     in  ID_WD    index holding highest priority this cycle
//     gnt_id  out ID_WD    winning index (0 when nothing requests)
//     gnt_vld out 1        at least one request present
// -----------------------------------------------------------------------------
module stream_rr_arbiter_rr_pick
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_WD   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_WD-1:0]   ptr,
  output logic [ID_WD-1:0]   gnt_id,
  output logic               gnt_vld
);

  // Index reached after stepping ofs positions from base, with wrap.
  function automatic logic [ID_WD-1:0] f_rot(input logic [ID_WD-1:0] base,
                                             input int unsigned       ofs);
    return ID_WD'((32'(base) + ofs) % NUM_REQ);
  endfunction

  always_comb begin
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req[f_rot(ptr, k)]) begin
        gnt_id  = f_rot(ptr, k);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
//   Shares one downstream valid/ready stream among NUM_REQ upstream streams.
//   Round-robin arbitration at packet granularity: a winner keeps the grant
//   until its last beat is accepted. A single registered output slot gives a
//   fixed one-cycle latency and carries the source index with every beat.
//   Ports:
//     clk  in  1          rising-edge clock
//     rst  in  1          asynchronous active-high reset
//     bus  slave modport  upstream pre-streams and downstream post-stream
// -----------------------------------------------------------------------------
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_WD = DEF_DATA_WD,
  parameter int unsigned ID_WD   = clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  stream_rr_arbiter_if.slave  bus
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ID_WD-1:0]   r_rr_ptr;
  logic [ID_WD-1:0]   w_rr_ptr_nxt;
  logic [ID_WD-1:0]   r_lock_id;
  logic [ID_WD-1:0]   w_lock_id_nxt;

  logic               r_valid_post;
  logic [DATA_WD-1:0] r_data_post;
  logic               r_last_post;
  logic [ID_WD-1:0]   r_id_post;

  logic               w_slot_free;
  logic [ID_WD-1:0]   w_pick_id;
  logic               w_pick_vld;
  logic [ID_WD-1:0]   w_sel_id;
  logic               w_sel_en;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic [DATA_WD-1:0] w_sel_data;
  logic               w_sel_last;

  function automatic logic [ID_WD-1:0] f_next(input logic [ID_WD-1:0] id);
    if (id == ID_WD'(NUM_REQ - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  // The output slot can take a new beat when empty or draining this cycle.
  assign w_slot_free = ~r_valid_post | bus.ready_post_i;

  stream_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_WD   (ID_WD)
  ) u_rr_pick (
    .req     (bus.valid_pre_i),
    .ptr     (r_rr_ptr),
    .gnt_id  (w_pick_id),
    .gnt_vld (w_pick_vld)
  );

  // Selected requester: the round-robin winner while idle, the packet owner
  // while locked. The owner is offered ready even through valid gaps.
  always_comb begin
    w_sel_id = w_pick_id;
    w_sel_en = w_pick_vld;
    if (r_state == ST_LOCK) begin
      w_sel_id = r_lock_id;
      w_sel_en = 1'b1;
    end
  end

  // Ready steering and beat mux use constant indices per requester so the
  // selected id is only ever compared, never used as a variable index.
  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (w_sel_id == ID_WD'(r)) begin
        w_ready[r] = w_sel_en & w_slot_free & ~rst;
        w_sel_data = bus.data_pre_i[r*DATA_WD +: DATA_WD];
        w_sel_last = bus.last_pre_i[r];
      end
    end
  end

  assign w_accept = |(bus.valid_pre_i & w_ready);

  // Next-state logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_rr_ptr_nxt = f_next(w_sel_id);
          end else begin
            w_state_nxt   = ST_LOCK;
            w_lock_id_nxt = w_sel_id;
          end
        end
      end
      ST_LOCK: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = f_next(r_lock_id);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  // Output slot: load on accept, otherwise empty when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_post <= 1'b0;
      r_data_post  <= '0;
      r_last_post  <= 1'b0;
      r_id_post    <= '0;
    end else if (w_accept) begin
      r_valid_post <= 1'b1;
      r_data_post  <= w_sel_data;
      r_last_post  <= w_sel_last;
      r_id_post    <= w_sel_id;
    end else if (bus.ready_post_i) begin
      r_valid_post <= 1'b0;
    end
  end

  assign bus.ready_pre_o  = w_ready;
  assign bus.valid_post_o = r_valid_post;
  assign bus.data_post_o  = r_data_post;
  assign bus.last_post_o  = r_last_post;
  assign bus.id_post_o    = r_id_post;

endmodule
